// File: rtl/video_driver.sv
// video_driver: raster timing generator and pixel sink feeding the TMDS encoder.
// Optional macro VIDEO_DRIVER_BORDER_EN forces a white ring on the outermost active pixels.
module video_driver #(
  parameter logic [10:0] H_SYNC   = 11'd40,
  parameter logic [10:0] H_BACK   = 11'd220,
  parameter logic [10:0] H_DISP   = 11'd1280,
  parameter logic [10:0] H_FRONT  = 11'd110,
  parameter logic [10:0] V_SYNC   = 11'd5,
  parameter logic [10:0] V_BACK   = 11'd20,
  parameter logic [10:0] V_DISP   = 11'd720,
  parameter logic [10:0] V_FRONT  = 11'd5,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb
);

  localparam logic [10:0] H_TOTAL   = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [10:0] V_TOTAL   = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [10:0] HA        = H_SYNC + H_BACK;
  localparam logic [10:0] VA        = V_SYNC + V_BACK;
  localparam logic [10:0] H_END     = HA + H_DISP;
  localparam logic [10:0] V_END     = VA + V_DISP;
  localparam logic [10:0] H_REQ     = HA - 11'd1;
  localparam logic [10:0] H_REQ_END = H_END - 11'd1;

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        hs_c;
  logic        vs_c;
  logic        v_act;
  logic        de_c;
  logic        req_c;
  logic [23:0] rgb_p0;

  // Stage p0: raster counters; v_cnt advances on the h_cnt wrap
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_TOTAL - 11'd1) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_TOTAL - 11'd1) ? 11'd0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign hs_c  = h_cnt < H_SYNC;
  assign vs_c  = v_cnt < V_SYNC;
  assign v_act = (v_cnt >= VA) && (v_cnt < V_END);
  assign de_c  = v_act && (h_cnt >= HA) && (h_cnt < H_END);
  // Request window leads de by one cycle to cover the generator's register
  assign req_c = v_act && (h_cnt >= H_REQ) && (h_cnt < H_REQ_END);

  assign pixel_xpos = req_c ? h_cnt - H_REQ : 11'd0;
  assign pixel_ypos = req_c ? v_cnt - VA : 11'd0;

`ifdef VIDEO_DRIVER_BORDER_EN
  logic [10:0] x_p1;
  logic [10:0] y_p1;

  function automatic logic on_ring(input logic [10:0] x, input logic [10:0] y);
    return (x == 11'd0) || (x == H_DISP - 11'd1) || (y == 11'd0) || (y == V_DISP - 11'd1);
  endfunction

  // Stage p1: coordinates travel with the returned pixel_data
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      x_p1 <= '0;
      y_p1 <= '0;
    end else begin
      x_p1 <= pixel_xpos;
      y_p1 <= pixel_ypos;
    end
  end

  assign rgb_p0 = on_ring(x_p1, y_p1) ? 24'hFFFFFF : pixel_data;
`else
  assign rgb_p0 = pixel_data;
`endif

  // Stage p1: registered video outputs to the encoder
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      video_hs  <= ~SYNC_POL;
      video_vs  <= ~SYNC_POL;
      video_de  <= 1'b0;
      video_rgb <= '0;
    end else begin
      video_hs  <= hs_c ? SYNC_POL : ~SYNC_POL;
      video_vs  <= vs_c ? SYNC_POL : ~SYNC_POL;
      video_de  <= de_c;
      video_rgb <= de_c ? rgb_p0 : 24'd0;
    end
  end

endmodule

// File: tb/tb_video_driver.sv
// tb_video_driver: directed checks of the default 1280x720 raster and a 14x7 small raster.
module tb_video_driver;

`ifdef VIDEO_DRIVER_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        rst_b = 1'b0;
  logic [23:0] pd_a = 24'd0;
  logic [23:0] pd_b = 24'd0;
  logic [10:0] xa, ya, xb, yb;
  logic        hs_a, vs_a, de_a, hs_b, vs_b, de_b;
  logic [23:0] rgb_a, rgb_b;

  int n_vec = 0;
  int n_bad = 0;

  // Small raster tables, bit index = h_cnt (14) or v_cnt (7)
  logic [13:0] hs_tab  = 14'b00000000000011;
  logic [13:0] de_tab  = 14'b00111111110000;
  logic [13:0] req_tab = 14'b00011111111000;
  logic [6:0]  vs_tab  = 7'b0000001;
  logic [6:0]  act_tab = 7'b0111100;

  always #5 clk = ~clk;

  video_driver u_dut_a (
    .pixel_clk(clk), .sys_rst(rst_a), .pixel_data(pd_a),
    .pixel_xpos(xa), .pixel_ypos(ya),
    .video_hs(hs_a), .video_vs(vs_a), .video_de(de_a), .video_rgb(rgb_a)
  );

  video_driver #(
    .H_SYNC(11'd2), .H_BACK(11'd2), .H_DISP(11'd8), .H_FRONT(11'd2),
    .V_SYNC(11'd1), .V_BACK(11'd1), .V_DISP(11'd4), .V_FRONT(11'd1)
  ) u_dut_b (
    .pixel_clk(clk), .sys_rst(rst_b), .pixel_data(pd_b),
    .pixel_xpos(xb), .pixel_ypos(yb),
    .video_hs(hs_b), .video_vs(vs_b), .video_de(de_b), .video_rgb(rgb_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    pd_a  = 24'hABCDEF;
    pd_b  = 24'hABCDEF;
    #2;
    for (int r = 0; r < 2; r++) begin
      n_vec++; if ({hs_a, vs_a, de_a} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl_a got %b exp 000", {hs_a, vs_a, de_a}); end
      n_vec++; if (rgb_a !== 24'd0) begin n_bad++; $display("FAIL reset_rgb_a got %h exp 000000", rgb_a); end
      n_vec++; if ({xa, ya} !== 22'd0) begin n_bad++; $display("FAIL reset_pos_a got %0d,%0d exp 0,0", xa, ya); end
      n_vec++; if ({hs_b, vs_b, de_b} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl_b got %b exp 000", {hs_b, vs_b, de_b}); end
      n_vec++; if (rgb_b !== 24'd0) begin n_bad++; $display("FAIL reset_rgb_b got %h exp 000000", rgb_b); end
      repeat (3) step();
    end
  endtask

  // Samples k = 0..1650 after release; hs high for k%1650 < 40
  task automatic test_line_timing();
    int hi;
    logic e;
    hi = 0;
    @(negedge clk) rst_a = 1'b0;
    for (int k = 0; k <= 1650; k++) begin
      step();
      e = (k % 1650) < 40;
      if (k < 1650 && hs_a === 1'b1) hi++;
      n_vec++; if (hs_a !== e) begin n_bad++; $display("FAIL line_hs k=%0d got %b exp %b", k, hs_a, e); end
      n_vec++; if (vs_a !== 1'b1) begin n_bad++; $display("FAIL line_vs k=%0d got %b exp 1", k, vs_a); end
    end
    n_vec++; if (hi != 40) begin n_bad++; $display("FAIL hs_width got %0d exp 40", hi); end
  endtask

  // Lines 1..24: blanking, junk data must never reach video_rgb
  task automatic test_vblank();
    int vs_hi;
    logic e;
    vs_hi = 1651;
    for (int k = 1651; k < 41250; k++) begin
      step();
      if (vs_a === 1'b1) vs_hi++;
      e = (k % 1650) < 40;
      n_vec++; if (hs_a !== e) begin n_bad++; $display("FAIL vb_hs k=%0d got %b exp %b", k, hs_a, e); end
      e = k < 8250;
      n_vec++; if (vs_a !== e) begin n_bad++; $display("FAIL vb_vs k=%0d got %b exp %b", k, vs_a, e); end
      n_vec++; if (de_a !== 1'b0 || rgb_a !== 24'd0) begin n_bad++; $display("FAIL vb_de_rgb k=%0d got %b/%h exp 0/000000", k, de_a, rgb_a); end
      n_vec++; if (xa !== 11'd0 || ya !== 11'd0) begin n_bad++; $display("FAIL vb_pos k=%0d got %0d,%0d exp 0,0", k, xa, ya); end
    end
    n_vec++; if (vs_hi != 8250) begin n_bad++; $display("FAIL vs_width got %0d exp 8250", vs_hi); end
  endtask

  // Line 25 (first active line): generator returns {13'd0, x} one cycle after request
  task automatic test_active_line();
    logic [10:0] x_prev;
    logic [23:0] e_rgb;
    logic [10:0] e_x;
    logic        e_de;
    int h, hn, hp, de_cnt, first_de;
    x_prev = 11'd0;
    de_cnt = 0;
    first_de = -1;
    for (int k = 41250; k < 42900; k++) begin
      hp = (k - 1) % 1650;
      pd_a = (k - 1 >= 41250 && hp >= 259 && hp < 1539) ? {13'd0, x_prev} : 24'hABCDEF;
      x_prev = xa;
      step();
      h  = k - 41250;
      hn = (k + 1) % 1650;
      e_de = (h >= 260) && (h < 1540);
      e_rgb = e_de ? (BORDER ? 24'hFFFFFF : 24'(h - 260)) : 24'd0;
      e_x = (hn >= 259 && hn < 1539) ? 11'(hn - 259) : 11'd0;
      if (de_a === 1'b1) begin de_cnt++; if (first_de < 0) first_de = k; end
      n_vec++; if (de_a !== e_de) begin n_bad++; $display("FAIL act_de h=%0d got %b exp %b", h, de_a, e_de); end
      n_vec++; if (rgb_a !== e_rgb) begin n_bad++; $display("FAIL act_rgb h=%0d got %h exp %h", h, rgb_a, e_rgb); end
      n_vec++; if (xa !== e_x || ya !== 11'd0) begin n_bad++; $display("FAIL act_pos h=%0d got %0d,%0d exp %0d,0", h, xa, ya, e_x); end
      n_vec++; if (hs_a !== (h < 40)) begin n_bad++; $display("FAIL act_hs h=%0d got %b", h, hs_a); end
    end
    n_vec++; if (de_cnt != 1280) begin n_bad++; $display("FAIL de_count got %0d exp 1280", de_cnt); end
    n_vec++; if (first_de != 41510) begin n_bad++; $display("FAIL first_de got %0d exp 41510", first_de); end
  endtask

  // Async reset in the middle of active line 26, then raster restarts at hsync
  task automatic test_reset_midline();
    int hi;
    logic e;
    pd_a = 24'h123456;
    repeat (400) step();
    n_vec++; if (de_a !== 1'b1 || rgb_a !== 24'h123456) begin n_bad++; $display("FAIL pre_rst got %b/%h exp 1/123456", de_a, rgb_a); end
    #2 rst_a = 1'b1;
    #1;
    n_vec++; if ({hs_a, vs_a, de_a} !== 3'b000) begin n_bad++; $display("FAIL mid_rst_ctl got %b exp 000", {hs_a, vs_a, de_a}); end
    n_vec++; if (rgb_a !== 24'd0) begin n_bad++; $display("FAIL mid_rst_rgb got %h exp 000000", rgb_a); end
    n_vec++; if (xa !== 11'd0 || ya !== 11'd0) begin n_bad++; $display("FAIL mid_rst_pos got %0d,%0d exp 0,0", xa, ya); end
    repeat (3) step();
    @(negedge clk) rst_a = 1'b0;
    hi = 0;
    for (int k = 0; k < 46; k++) begin
      step();
      e = k < 40;
      if (hs_a === 1'b1) hi++;
      n_vec++; if (hs_a !== e || vs_a !== 1'b1) begin n_bad++; $display("FAIL post_rst_sync k=%0d got %b%b exp %b1", k, hs_a, vs_a, e); end
    end
    n_vec++; if (hi != 40) begin n_bad++; $display("FAIL post_rst_hs_width got %0d exp 40", hi); end
  endtask

  // Two full small-raster frames with loopback data {2'b0, y, x}
  task automatic test_small_raster();
    logic [10:0] x_prev, y_prev, e_x, e_y;
    logic [23:0] e_rgb;
    logic        e_de, ring;
    int h, v, hn, vn, hp, vp, de_cnt, line_cnt, line_de;
    x_prev = 11'd0; y_prev = 11'd0; de_cnt = 0; line_cnt = 0; line_de = 0;
    @(negedge clk) rst_b = 1'b0;
    for (int k = 0; k < 196; k++) begin
      pd_b = 24'hABCDEF;
      if (k >= 1) begin
        hp = (k - 1) % 14; vp = ((k - 1) / 14) % 7;
        if (req_tab[hp] && act_tab[vp]) pd_b = {2'b00, y_prev, x_prev};
      end
      x_prev = xb; y_prev = yb;
      step();
      h = k % 14; v = (k / 14) % 7; hn = (k + 1) % 14; vn = ((k + 1) / 14) % 7;
      e_de = de_tab[h] & act_tab[v];
      ring = (h == 4) || (h == 11) || (v == 2) || (v == 5);
      e_rgb = !e_de ? 24'd0 : (BORDER && ring) ? 24'hFFFFFF : {2'b00, 11'(v - 2), 11'(h - 4)};
      e_x = (req_tab[hn] && act_tab[vn]) ? 11'(hn - 3) : 11'd0;
      e_y = (req_tab[hn] && act_tab[vn]) ? 11'(vn - 2) : 11'd0;
      if (de_b === 1'b1) begin de_cnt++; line_de++; end
      if (h == 13) begin if (line_de == 8) line_cnt++; line_de = 0; end
      n_vec++; if ({hs_b, vs_b, de_b} !== {hs_tab[h], vs_tab[v], e_de}) begin n_bad++; $display("FAIL sm_ctl h=%0d v=%0d got %b exp %b", h, v, {hs_b, vs_b, de_b}, {hs_tab[h], vs_tab[v], e_de}); end
      n_vec++; if (rgb_b !== e_rgb) begin n_bad++; $display("FAIL sm_rgb h=%0d v=%0d got %h exp %h", h, v, rgb_b, e_rgb); end
      n_vec++; if (xb !== e_x || yb !== e_y) begin n_bad++; $display("FAIL sm_pos k=%0d got %0d,%0d exp %0d,%0d", k, xb, yb, e_x, e_y); end
      if (k == 97) begin n_vec++; if ({hs_b, vs_b} !== 2'b00) begin n_bad++; $display("FAIL sm_prewrap got %b%b exp 00", hs_b, vs_b); end end
      if (k == 98) begin n_vec++; if ({hs_b, vs_b} !== 2'b11) begin n_bad++; $display("FAIL sm_wrap got %b%b exp 11", hs_b, vs_b); end end
    end
    n_vec++; if (de_cnt != 64) begin n_bad++; $display("FAIL sm_de_count got %0d exp 64", de_cnt); end
    n_vec++; if (line_cnt != 8) begin n_bad++; $display("FAIL sm_active_lines got %0d exp 8", line_cnt); end
  endtask

  // Third frame with black input: only the ring may light up
  task automatic test_border();
    logic [23:0] e_rgb;
    logic        ring;
    int h, v;
    pd_b = 24'd0;
    for (int k = 196; k < 294; k++) begin
      step();
      h = k % 14; v = (k / 14) % 7;
      ring = (h == 4) || (h == 11) || (v == 2) || (v == 5);
      e_rgb = (de_tab[h] && act_tab[v] && BORDER && ring) ? 24'hFFFFFF : 24'd0;
      n_vec++; if (rgb_b !== e_rgb) begin n_bad++; $display("FAIL border h=%0d v=%0d got %h exp %h", h, v, rgb_b, e_rgb); end
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_vblank();
    test_active_line();
    test_reset_midline();
    test_small_raster();
    test_border();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
